// File: rtl/pic_init_cmd_ctrl.sv
// 8259-style command decoder: walks the ICW1..ICW4 initialisation sequence,
// then decodes OCW1/OCW2/OCW3 into mask/config registers and one-cycle strobes.
module pic_init_cmd_ctrl #(
  parameter int         DATA_W   = 8,
  parameter logic [7:0] IMR_INIT = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_stb,
  input  logic              a0,
  input  logic [DATA_W-1:0] din,
  output logic              init_done,
  output logic [2:0]        icw_state,
  output logic              ltim,
  output logic              single,
  output logic              ic4,
  output logic [4:0]        vec_base,
  output logic [7:0]        icw3,
  output logic              upm,
  output logic              aeoi,
  output logic              ms,
  output logic              buf_mode,
  output logic              sfnm,
  output logic [7:0]        imr,
  output logic              ocw2_stb,
  output logic              ocw2_r,
  output logic              ocw2_sl,
  output logic              ocw2_eoi,
  output logic [2:0]        ocw2_lvl,
  output logic              rot_aeoi,
  output logic              smm,
  output logic              ris,
  output logic              poll_stb
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  state_t state, next_state;
  logic   icw1_hit;

  // ICW1 is recognised in every state, so it always restarts the sequence.
  assign icw1_hit  = wr_stb && !a0 && din[4];
  assign icw_state = state;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    if (icw1_hit) begin
      next_state = WAIT_ICW2;
    end else if (wr_stb && a0) begin
      case (state)
        WAIT_ICW2: next_state = !single ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
        WAIT_ICW3: next_state = ic4 ? WAIT_ICW4 : READY;
        WAIT_ICW4: next_state = READY;
        default:   next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_done <= 1'b0;
      ltim      <= 1'b0;
      single    <= 1'b0;
      ic4       <= 1'b0;
      vec_base  <= '0;
      icw3      <= '0;
      upm       <= 1'b0;
      aeoi      <= 1'b0;
      ms        <= 1'b0;
      buf_mode  <= 1'b0;
      sfnm      <= 1'b0;
      imr       <= IMR_INIT;
      ocw2_stb  <= 1'b0;
      ocw2_r    <= 1'b0;
      ocw2_sl   <= 1'b0;
      ocw2_eoi  <= 1'b0;
      ocw2_lvl  <= '0;
      rot_aeoi  <= 1'b0;
      smm       <= 1'b0;
      ris       <= 1'b0;
      poll_stb  <= 1'b0;
    end else begin
      ocw2_stb  <= 1'b0;
      poll_stb  <= 1'b0;
      init_done <= (next_state == READY);
      if (icw1_hit) begin
        ltim     <= din[3];
        single   <= din[1];
        ic4      <= din[0];
        imr      <= IMR_INIT;
        smm      <= 1'b0;
        ris      <= 1'b0;
        rot_aeoi <= 1'b0;
        upm      <= 1'b0;
        aeoi     <= 1'b0;
        ms       <= 1'b0;
        buf_mode <= 1'b0;
        sfnm     <= 1'b0;
      end else if (wr_stb && a0) begin
        case (state)
          WAIT_ICW2: vec_base <= din[7:3];
          WAIT_ICW3: icw3     <= din;
          WAIT_ICW4: begin
            upm      <= din[0];
            aeoi     <= din[1];
            ms       <= din[2];
            buf_mode <= din[3];
            sfnm     <= din[4];
          end
          READY:     imr <= din;
          default:   ;
        endcase
      end else if (wr_stb && state == READY) begin
        // Here din[4] is known to be 0, so din[3] alone picks OCW2 vs OCW3.
        if (!din[3]) begin
          ocw2_r   <= din[7];
          ocw2_sl  <= din[6];
          ocw2_eoi <= din[5];
          ocw2_lvl <= din[2:0];
          ocw2_stb <= 1'b1;
          if (din[7:5] == 3'b100)      rot_aeoi <= 1'b1;
          else if (din[7:5] == 3'b000) rot_aeoi <= 1'b0;
        end else begin
          if (din[6]) smm      <= din[5];
          if (din[1]) ris      <= din[0];
          if (din[2]) poll_stb <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pic_init_cmd_ctrl.sv
// Bench for pic_init_cmd_ctrl: a reference model pushes the expected output
// snapshot per cycle into a queue; it is popped and compared after the edge.
module tb_pic_init_cmd_ctrl;

  localparam logic [7:0] IMR_INIT = 8'hFF;

  typedef struct packed {
    logic [2:0] st;
    logic       done, ltim, single, ic4;
    logic [4:0] vb;
    logic [7:0] icw3;
    logic       upm, aeoi, ms, bufm, sfnm;
    logic [7:0] imr;
    logic       o2s, r, sl, eoi;
    logic [2:0] lvl;
    logic       rot, smm, ris, poll;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0, wr_stb = 1'b0, a0 = 1'b0;
  logic [7:0] din = 8'h00;

  logic       init_done, ltim, single, ic4, upm, aeoi, ms, buf_mode, sfnm;
  logic [2:0] icw_state, ocw2_lvl;
  logic [4:0] vec_base;
  logic [7:0] icw3, imr;
  logic       ocw2_stb, ocw2_r, ocw2_sl, ocw2_eoi, rot_aeoi, smm, ris, poll_stb;

  int vectors = 0;
  int miscompares = 0;

  snap_t m;
  snap_t sb[$];

  always #5 clk = ~clk;

  pic_init_cmd_ctrl #(.DATA_W(8), .IMR_INIT(IMR_INIT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .a0(a0), .din(din),
    .init_done(init_done), .icw_state(icw_state), .ltim(ltim), .single(single),
    .ic4(ic4), .vec_base(vec_base), .icw3(icw3), .upm(upm), .aeoi(aeoi),
    .ms(ms), .buf_mode(buf_mode), .sfnm(sfnm), .imr(imr), .ocw2_stb(ocw2_stb),
    .ocw2_r(ocw2_r), .ocw2_sl(ocw2_sl), .ocw2_eoi(ocw2_eoi), .ocw2_lvl(ocw2_lvl),
    .rot_aeoi(rot_aeoi), .smm(smm), .ris(ris), .poll_stb(poll_stb)
  );

  function automatic snap_t dut_snap();
    snap_t s;
    s = '{icw_state, init_done, ltim, single, ic4, vec_base, icw3,
          upm, aeoi, ms, buf_mode, sfnm, imr, ocw2_stb, ocw2_r, ocw2_sl,
          ocw2_eoi, ocw2_lvl, rot_aeoi, smm, ris, poll_stb};
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge with the given inputs.
  function automatic snap_t model(input snap_t c, input logic rst, input logic wr,
                                  input logic a, input logic [7:0] d);
    snap_t n = c;
    n.o2s  = 1'b0;
    n.poll = 1'b0;
    if (!rst) begin
      n = '0;
      n.imr = IMR_INIT;
      return n;
    end
    if (!wr) return n;
    if (!a && d[4]) begin
      {n.ltim, n.single, n.ic4} = {d[3], d[1], d[0]};
      n.imr = IMR_INIT;
      {n.smm, n.ris, n.rot} = 3'b000;
      {n.upm, n.aeoi, n.ms, n.bufm, n.sfnm} = 5'b0;
      n.st = 3'd1;
    end else begin
      case (c.st)
        3'd1: if (a) begin
          n.vb = d[7:3];
          n.st = !c.single ? 3'd2 : (c.ic4 ? 3'd3 : 3'd4);
        end
        3'd2: if (a) begin
          n.icw3 = d;
          n.st = c.ic4 ? 3'd3 : 3'd4;
        end
        3'd3: if (a) begin
          {n.sfnm, n.bufm, n.ms, n.aeoi, n.upm} = d[4:0];
          n.st = 3'd4;
        end
        3'd4: begin
          if (a) n.imr = d;
          else if (d[4:3] == 2'b00) begin
            {n.r, n.sl, n.eoi} = d[7:5];
            n.lvl = d[2:0];
            n.o2s = 1'b1;
            if (d[7:5] == 3'b100) n.rot = 1'b1;
            if (d[7:5] == 3'b000) n.rot = 1'b0;
          end else begin
            if (d[6]) n.smm = d[5];
            if (d[1]) n.ris = d[0];
            n.poll = d[2];
          end
        end
        default: ;
      endcase
    end
    n.done = (n.st == 3'd4);
    return n;
  endfunction

  // Drive one cycle, push the expected snapshot, compare after the edge.
  task automatic step(input logic r, input logic w, input logic a,
                      input logic [7:0] d, input string tag);
    snap_t exp;
    rst_n = r; wr_stb = w; a0 = a; din = d;
    m = model(m, r, w, a, d);
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 64'd1, 64'd0);
    end else begin
      exp = sb.pop_front();
      check(tag, 64'(dut_snap()), 64'(exp));
    end
    wr_stb = 1'b0;
  endtask

  initial begin
    m = '0;
    // Reset and single/IC4 sequence.
    step(0, 0, 0, 8'h00, "reset");
    check("reset_imr", 64'(imr), 64'(IMR_INIT));
    step(1, 1, 0, 8'h13, "s1_icw1");
    check("s1_state1", 64'(icw_state), 64'd1);
    step(1, 1, 1, 8'h20, "s1_icw2");
    check("s1_state3", 64'(icw_state), 64'd3);
    step(1, 1, 1, 8'h03, "s1_icw4");
    check("s1_done", 64'({icw_state, init_done, vec_base, upm, aeoi, icw3}),
          64'({3'd4, 1'b1, 5'h04, 1'b1, 1'b1, 8'h00}));
    step(1, 0, 0, 8'h13, "s1_no_wr");

    // Cascade sequence with a held a0=0 write inside a WAIT state.
    step(1, 1, 0, 8'h11, "s2_icw1");
    step(1, 1, 1, 8'h40, "s2_icw2");
    step(1, 1, 0, 8'h00, "s2_ignored");
    step(1, 1, 1, 8'h04, "s2_icw3");
    check("s2_not_ready", 64'({icw_state, init_done}), 64'({3'd3, 1'b0}));
    step(1, 1, 1, 8'h01, "s2_icw4");
    check("s2_icw3_done", 64'({icw3, init_done, upm}), 64'({8'h04, 1'b1, 1'b1}));

    // OCW1 then ICW1 restart, back-to-back re-init.
    step(1, 1, 1, 8'hA5, "ocw1");
    check("ocw1_imr", 64'(imr), 64'hA5);
    step(1, 1, 0, 8'h13, "re_icw1");
    check("re_icw1", 64'({imr, init_done, icw_state}), 64'({IMR_INIT, 1'b0, 3'd1}));
    step(1, 1, 1, 8'h20, "re_icw2");
    step(1, 1, 1, 8'h03, "re_icw4");

    // OCW2 variants.
    step(1, 1, 0, 8'h62, "ocw2_62");
    check("ocw2_62", 64'({ocw2_stb, ocw2_r, ocw2_sl, ocw2_eoi, ocw2_lvl}),
          64'({1'b1, 1'b0, 1'b1, 1'b1, 3'd2}));
    step(1, 0, 0, 8'h00, "ocw2_stb_drop");
    check("ocw2_one_cycle", 64'(ocw2_stb), 64'd0);
    step(1, 1, 0, 8'h80, "ocw2_80");
    check("rot_set", 64'(rot_aeoi), 64'd1);
    step(1, 1, 0, 8'h00, "ocw2_00");
    check("rot_clr", 64'({rot_aeoi, ocw2_stb}), 64'({1'b0, 1'b1}));

    // OCW3 variants.
    step(1, 1, 0, 8'h6B, "ocw3_6b");
    check("ocw3_6b", 64'({smm, ris, poll_stb}), 64'({1'b1, 1'b1, 1'b0}));
    step(1, 1, 0, 8'h0C, "ocw3_0c");
    check("ocw3_poll", 64'({smm, ris, poll_stb}), 64'({1'b1, 1'b1, 1'b1}));
    step(1, 0, 0, 8'h00, "poll_drop");
    step(1, 1, 0, 8'h4A, "ocw3_4a");

    // Writes before init are ignored; reset mid-sequence.
    step(0, 0, 0, 8'h00, "reset2");
    step(1, 1, 1, 8'h5A, "pre_ocw1");
    step(1, 1, 1, 8'hFF, "pre_ocw1_ff");
    step(1, 1, 0, 8'h20, "pre_ocw2");
    check("pre_init", 64'({imr, ocw2_stb, icw_state}), 64'({IMR_INIT, 1'b0, 3'd0}));
    step(1, 1, 0, 8'h19, "c_icw1");
    step(1, 1, 1, 8'hF8, "c_icw2");
    step(1, 1, 0, 8'h20, "c_wait3_ocw2");
    check("c_in_wait3", 64'({icw_state, ocw2_stb}), 64'({3'd2, 1'b0}));
    step(0, 1, 1, 8'h04, "reset_mid");
    check("reset_mid", 64'({icw_state, init_done, ltim, vec_base, imr}),
          64'({3'd0, 1'b0, 1'b0, 5'h00, IMR_INIT}));

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pic_init_cmd_ctrl.md
Name: pic_init_cmd_ctrl

Overview:
- Command-decode stage directly downstream of the PIC data bus buffer.
- Consumes each byte the CPU writes through the buffer, qualified by A0.
- Runs the 8259-style ICW1..ICW4 initialisation sequence, then decodes OCW1/OCW2/OCW3.
- Holds the resulting configuration and mask registers and issues one-cycle command strobes to the priority/ISR logic.

Parameters:
- DATA_W, 8, data byte width; only 8 is supported.
- IMR_INIT, 8'h00, IMR value after reset and after every ICW1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- wr_stb  in  1  one-cycle write strobe from the data bus buffer.
- a0  in  1  address bit A0 qualifying the write.
- din  in  8  write data from the data bus buffer.
- init_done  out  1  high once the ICW sequence completes.
- icw_state  out  3  current state encoding.
- ltim  out  1  ICW1 D3, level-triggered mode.
- single  out  1  ICW1 D1.
- ic4  out  1  ICW1 D0.
- vec_base  out  5  ICW2 D7..D3.
- icw3  out  8  ICW3 byte (cascade config).
- upm, aeoi, ms, buf_mode, sfnm  out  1 each  ICW4 D0, D1, D2, D3, D4.
- imr  out  8  interrupt mask register (OCW1).
- ocw2_stb  out  1  one-cycle pulse after an OCW2 write.
- ocw2_r, ocw2_sl, ocw2_eoi  out  1 each  OCW2 D7, D6, D5.
- ocw2_lvl  out  3  OCW2 D2..D0.
- rot_aeoi  out  1  rotate-in-AEOI mode flag.
- smm  out  1  special mask mode.
- ris  out  1  read-register select: 0 = IRR, 1 = ISR.
- poll_stb  out  1  one-cycle pulse on an OCW3 write with P=1.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - icw_state=IDLE; init_done=0.
  - All config registers, ocw2 fields, rot_aeoi, smm and ris = 0.
  - imr=IMR_INIT; strobes=0.
  - Reset mid-sequence abandons it.
- Latency: every register update and strobe appears on the clock edge following the cycle in which wr_stb=1. Strobes last exactly one cycle. No update happens when wr_stb=0.
- ICW1 detect: wr_stb & a0=0 & din[4]=1.
  - Accepted in any state, including mid-sequence; this restarts the sequence.
  - Actions: latch ltim/single/ic4; imr=IMR_INIT; clear smm, ris, rot_aeoi, init_done; clear all ICW4 fields. ICW4 fields are cleared even if IC4=1, until ICW4 arrives.
  - Next state: WAIT_ICW2.
- States and transitions (encoding: IDLE=0, WAIT_ICW2=1, WAIT_ICW3=2, WAIT_ICW4=3, READY=4):
  - IDLE: only ICW1 is acted on; every other write is ignored.
  - WAIT_ICW2, on an a0=1 write: latch vec_base=din[7:3]. Go to WAIT_ICW3 if single=0; else WAIT_ICW4 if ic4=1; else READY.
  - WAIT_ICW3, on an a0=1 write: latch icw3=din. Go to WAIT_ICW4 if ic4=1; else READY.
  - WAIT_ICW4, on an a0=1 write: latch upm=din[0], aeoi=din[1], ms=din[2], buf_mode=din[3], sfnm=din[4]. Go to READY.
  - In any WAIT state, an a0=0 write with din[4]=0 is ignored and the state is held.
  - Entering READY sets init_done=1 on the same edge.
- READY decode:
  - a0=1: OCW1, imr=din.
  - a0=0, din[4:3]=00: OCW2.
    - Latch r/sl/eoi/lvl and pulse ocw2_stb.
    - R,SL,EOI=100 sets rot_aeoi; 000 clears it.
    - The strobe fires for every OCW2, including these two.
  - a0=0, din[4:3]=01: OCW3.
    - If din[6]=1 (ESMM), smm=din[5].
    - If din[1]=1 (RR), ris=din[0].
    - If din[2]=1, pulse poll_stb. Polling has priority; smm/ris updates from the same byte still apply.
- OCW writes received before READY are never decoded as OCWs.
- Back-to-back wr_stb on consecutive cycles must each be processed.

Test Plan:
- Reset, then ICW1=0x13 (single, ic4), ICW2 a0=1 0x20, ICW4 a0=1 0x03 -> states 1 then 3 then 4; vec_base=5'h04; upm=1; aeoi=1; init_done=1 on the third edge; icw3 stays 0.
- ICW1=0x11 (cascade, ic4), ICW2 0x40, ICW3 0x04, ICW4 0x01 -> icw3=0x04; ICW4 is accepted only after ICW3; init_done=1 after the 4th write.
- In READY: a0=1 0xA5 -> imr=0xA5; then ICW1=0x13 -> imr=IMR_INIT, init_done=0, state=1.
- In READY: OCW2 0x62 -> ocw2_stb high exactly one cycle, sl=1, eoi=1, lvl=2. OCW2 0x80 -> rot_aeoi=1. OCW2 0x00 -> rot_aeoi=0.
- In READY: OCW3 0x6B -> smm=1, ris=1, no poll. OCW3 0x0C -> poll_stb one cycle, smm and ris unchanged.
- Before init: a0=1 0xFF and OCW2 0x20 -> imr unchanged, no ocw2_stb. rst_n=0 in WAIT_ICW3 -> IDLE and all outputs at reset values on the next edge.
